// File: rtl/umich_op_arbiter.sv
// Round-robin arbiter sharing one fixed-latency arithmetic unit among NREQ requesters,
// with an in-flight tag pipeline and a credit-protected response FIFO.
module umich_op_arbiter #(
   parameter int NREQ   = 4,
   parameter int W      = 64,
   parameter int OPW    = 4,
   parameter int LAT    = 2,
   parameter int RDEPTH = 4
) (
   input  logic                     clocked_on,
   input  logic                     preset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*W-1:0]        req_a,
   input  logic [NREQ*W-1:0]        req_b,
   input  logic [NREQ*OPW-1:0]      req_op,
   output logic                     alu_fire,
   output logic [W-1:0]             alu_a,
   output logic [W-1:0]             alu_b,
   output logic [OPW-1:0]           alu_op,
   input  logic [W-1:0]             alu_z,
   output logic                     rsp_valid,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [W-1:0]             rsp_z,
   input  logic                     rsp_ready,
   output logic                     busy
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(RDEPTH + 1);
   localparam int AW  = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] issue_id;
   logic [CW-1:0]  credit;
   logic [CW-1:0]  fifo_cnt;
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [IDW-1:0] grant_id;
   logic           grant_found;
   logic           can_issue;
   logic           transfer;
   logic           pop;
   logic           tag_out_v;
   logic [IDW-1:0] tag_out_id;

   assign can_issue = (credit < CW'(RDEPTH));

   always_comb begin
      int             idx;
      logic [IDW-1:0] sel;
      // NOTE: every variable gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
      grant_found = 1'b0;
      grant_id    = '0;
      idx         = 0;
      sel         = '0;
      for (int off = 0; off < NREQ; off++) begin
         idx = int'(ptr) + off;
         if (idx >= NREQ) idx = idx - NREQ;
         sel = IDW'(idx);
         if (can_issue && !grant_found && req_valid[sel]) begin
            grant_found = 1'b1;
            grant_id    = sel;
         end
      end
   end

   // Ready is held low while preset is asserted so nothing looks accepted during reset.
   always_comb begin
      req_ready = '0;
      if (grant_found && !preset) req_ready[grant_id] = 1'b1;
   end

   assign transfer = |(req_valid & req_ready);
   assign pop      = rsp_valid & rsp_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clocked_on or posedge preset) begin
      if (preset) begin
         alu_fire <= 1'b0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= '0;
         ptr      <= '0;
         issue_id <= '0;
      end else begin
         alu_fire <= transfer;
         if (transfer) begin
            alu_a    <= req_a[grant_id*W +: W];
            alu_b    <= req_b[grant_id*W +: W];
            alu_op   <= req_op[grant_id*OPW +: OPW];
            issue_id <= grant_id;
            ptr      <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
         end
      end
   end

   generate
      if (LAT == 0) begin : g_lat0
         assign tag_out_v  = alu_fire;
         assign tag_out_id = issue_id;
      end else begin : g_tags
         logic [LAT-1:0] tag_v;
         logic [IDW-1:0] tag_id [LAT];

         always_ff @(posedge clocked_on or posedge preset) begin
            if (preset) begin
               for (int i = 0; i < LAT; i++) begin
                  tag_v[i]  <= 1'b0;
                  tag_id[i] <= '0;
               end
            end else begin
               tag_v[0]  <= alu_fire;
               tag_id[0] <= issue_id;
               for (int i = 1; i < LAT; i++) begin
                  tag_v[i]  <= tag_v[i-1];
                  tag_id[i] <= tag_id[i-1];
               end
            end
         end

         assign tag_out_v  = tag_v[LAT-1];
         assign tag_out_id = tag_id[LAT-1];
      end
   endgenerate

   logic [IDW+W-1:0] mem [RDEPTH];
   logic [IDW-1:0]   head_id;
   logic [W-1:0]     head_z;

   // NOTE: storage is deliberately not reset; fifo_cnt alone decides which entries are meaningful.
   always_ff @(posedge clocked_on) begin
      if (tag_out_v) mem[wr_ptr] <= {tag_out_id, alu_z};
   end

   always_ff @(posedge clocked_on or posedge preset) begin
      if (preset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         credit   <= '0;
      end else begin
         if (tag_out_v) wr_ptr <= (wr_ptr == AW'(RDEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)       rd_ptr <= (rd_ptr == AW'(RDEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({tag_out_v, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
         // A credit is held from acceptance until its result leaves the FIFO.
         case ({transfer, pop})
            2'b10:   credit <= credit + 1'b1;
            2'b01:   credit <= credit - 1'b1;
            default: credit <= credit;
         endcase
      end
   end

   assign {head_id, head_z} = mem[rd_ptr];
   assign rsp_valid = (fifo_cnt != '0);
   assign rsp_id    = rsp_valid ? head_id : '0;
   assign rsp_z     = rsp_valid ? head_z : '0;
   assign busy      = (credit != '0);

endmodule

// File: tb/tb_umich_op_arbiter.sv
// Bench for umich_op_arbiter: a LAT=2 instance driven against a cycle model and
// scoreboard, plus a LAT=0 instance for the combinational-unit case.
module tb_umich_op_arbiter;

   localparam int NREQ   = 4;
   localparam int W      = 64;
   localparam int OPW    = 4;
   localparam int LAT    = 2;
   localparam int RDEPTH = 4;
   localparam int IDW    = $clog2(NREQ);

   localparam logic [OPW-1:0] OP_SUB = 4'd1;
   localparam logic [OPW-1:0] OP_ADD = 4'd2;
   localparam logic [OPW-1:0] OP_MUL = 4'd3;
   localparam logic [OPW-1:0] OP_LT  = 4'd4;
   localparam logic [OPW-1:0] OP_EQ  = 4'd5;

   logic clocked_on = 1'b0;
   logic preset     = 1'b1;
   always #5 clocked_on = ~clocked_on;

   logic [NREQ-1:0]     req_valid, req_ready;
   logic [NREQ*W-1:0]   req_a, req_b;
   logic [NREQ*OPW-1:0] req_op;
   logic                alu_fire, rsp_valid, rsp_ready, busy;
   logic [W-1:0]        alu_a, alu_b, alu_z, rsp_z;
   logic [OPW-1:0]      alu_op;
   logic [IDW-1:0]      rsp_id;

   logic [NREQ-1:0]     l0_req_valid, l0_req_ready;
   logic [NREQ*W-1:0]   l0_req_a, l0_req_b;
   logic [NREQ*OPW-1:0] l0_req_op;
   logic                l0_alu_fire, l0_rsp_valid, l0_rsp_ready, l0_busy;
   logic [W-1:0]        l0_alu_a, l0_alu_b, l0_alu_z, l0_rsp_z;
   logic [OPW-1:0]      l0_alu_op;
   logic [IDW-1:0]      l0_rsp_id;

   umich_op_arbiter #(.NREQ(NREQ), .W(W), .OPW(OPW), .LAT(LAT), .RDEPTH(RDEPTH)) dut (
      .clocked_on(clocked_on), .preset(preset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .alu_fire(alu_fire), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_ready(rsp_ready),
      .busy(busy)
   );

   umich_op_arbiter #(.NREQ(NREQ), .W(W), .OPW(OPW), .LAT(0), .RDEPTH(RDEPTH)) dut_lat0 (
      .clocked_on(clocked_on), .preset(preset),
      .req_valid(l0_req_valid), .req_ready(l0_req_ready),
      .req_a(l0_req_a), .req_b(l0_req_b), .req_op(l0_req_op),
      .alu_fire(l0_alu_fire), .alu_a(l0_alu_a), .alu_b(l0_alu_b), .alu_op(l0_alu_op),
      .alu_z(l0_alu_z),
      .rsp_valid(l0_rsp_valid), .rsp_id(l0_rsp_id), .rsp_z(l0_rsp_z), .rsp_ready(l0_rsp_ready),
      .busy(l0_busy)
   );

   function automatic logic [W-1:0] alu_f(logic [W-1:0] a, logic [W-1:0] b, logic [OPW-1:0] op);
      case (op)
         OP_SUB:  return a - b;
         OP_ADD:  return a + b;
         OP_MUL:  return a * b;
         OP_LT:   return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_EQ:   return {{(W-1){1'b0}}, (a == b)};
         default: return a ^ b;
      endcase
   endfunction

   // Shared unit models: two pipeline stages for the main instance, combinational for LAT=0.
   logic [W-1:0] zp1, zp2;
   always @(posedge clocked_on) begin
      zp1 <= alu_f(alu_a, alu_b, alu_op);
      zp2 <= zp1;
   end
   assign alu_z = zp2;
   always_comb l0_alu_z = alu_f(l0_alu_a, l0_alu_b, l0_alu_op);

   typedef struct {
      logic [IDW-1:0] id;
      logic [W-1:0]   z;
      int             vis;
   } exp_t;

   exp_t           sb[$];
   exp_t           q0[$];
   exp_t           e0;
   int             vectors    = 0;
   int             miscompares = 0;
   int             cyc        = 0;
   int             mptr       = 0;
   logic           m_fire     = 1'b0;
   logic [W-1:0]   m_a        = '0;
   logic [W-1:0]   m_b        = '0;
   logic [OPW-1:0] m_op       = '0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [OPW-1:0] op);
      req_a[i*W +: W]     = a;
      req_b[i*W +: W]     = b;
      req_op[i*OPW +: OPW] = op;
   endtask

   task automatic model_reset();
      sb.delete();
      mptr   = 0;
      m_fire = 1'b0;
      m_a    = '0;
      m_b    = '0;
      m_op   = '0;
   endtask

   task automatic reset_check(input string pfx);
      chk({pfx, "_req_ready"}, req_ready, '0);
      chk({pfx, "_alu_fire"}, alu_fire, 1'b0);
      chk({pfx, "_alu_a"}, alu_a, '0);
      chk({pfx, "_alu_b"}, alu_b, '0);
      chk({pfx, "_alu_op"}, alu_op, '0);
      chk({pfx, "_rsp_valid"}, rsp_valid, 1'b0);
      chk({pfx, "_rsp_id"}, rsp_id, '0);
      chk({pfx, "_rsp_z"}, rsp_z, '0);
      chk({pfx, "_busy"}, busy, 1'b0);
   endtask

   // One clock: check every output against the model at the falling edge, advance the
   // model as the DUT will at the rising edge, then refresh the granted requester's operands.
   task automatic tick();
      int              g;
      int              idx;
      logic [NREQ-1:0] exp_rdy;
      logic            m_valid;
      logic            do_pop;
      @(negedge clocked_on);
      g = -1;
      if (sb.size() < RDEPTH) begin
         for (int off = 0; off < NREQ; off++) begin
            idx = (mptr + off) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
      chk("req_ready", req_ready, exp_rdy);
      chk("alu_fire", alu_fire, m_fire);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", alu_op, m_op);
      chk("busy", busy, sb.size() != 0);
      m_valid = 1'b0;
      if (sb.size() > 0) m_valid = (sb[0].vis <= cyc);
      chk("rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
         chk("rsp_id", rsp_id, sb[0].id);
         chk("rsp_z", rsp_z, sb[0].z);
      end
      do_pop = m_valid && rsp_ready;
      m_fire = (g >= 0);
      if (g >= 0) begin
         m_a  = req_a[g*W +: W];
         m_b  = req_b[g*W +: W];
         m_op = req_op[g*OPW +: OPW];
         sb.push_back('{IDW'(g), alu_f(m_a, m_b, m_op), cyc + LAT + 2});
         mptr = (g + 1) % NREQ;
      end
      if (do_pop) void'(sb.pop_front());
      @(posedge clocked_on);
      cyc++;
      #1;
      if (g >= 0) set_req(g, {$urandom, $urandom}, {$urandom, $urandom}, OPW'($urandom_range(0, 7)));
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int n = 0; n < 40 && sb.size() > 0; n++) tick();
      tick();
   endtask

   initial begin
      req_valid    = '0;
      req_a        = '0;
      req_b        = '0;
      req_op       = '0;
      rsp_ready    = 1'b1;
      l0_req_valid = '0;
      l0_req_a     = '0;
      l0_req_b     = '0;
      l0_req_op    = '0;
      l0_rsp_ready = 1'b1;

      // Reset state.
      repeat (2) @(posedge clocked_on);
      #1;
      reset_check("rst");
      preset = 1'b0;

      // Single operation through the two-stage unit.
      set_req(0, 64'd5, 64'd7, OP_ADD);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      chk("single_fire", alu_fire, 1'b1);
      chk("single_a", alu_a, 64'd5);
      chk("single_b", alu_b, 64'd7);
      chk("single_op", alu_op, 4'd2);
      chk("single_busy", busy, 1'b1);
      tick();
      tick();
      chk("single_rsp_early", rsp_valid, 1'b0);
      tick();
      chk("single_rsp_valid", rsp_valid, 1'b1);
      chk("single_rsp_id", rsp_id, 2'd0);
      chk("single_rsp_z", rsp_z, 64'd12);
      tick();
      chk("single_busy_end", busy, 1'b0);

      // Fairness with everybody requesting.
      for (int i = 0; i < NREQ; i++)
         set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, OPW'($urandom_range(0, 7)));
      req_valid = '1;
      repeat (14) tick();
      drain();

      // Back-pressure: credits run out, then a single pop admits a single grant.
      rsp_ready = 1'b0;
      req_valid = '1;
      repeat (6) tick();
      chk("bp_stalled", req_ready, '0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      repeat (3) tick();
      drain();

      // Pointer skip and wrap with only requesters 1 and 3 active.
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b1010;
      #1;
      chk("wrap_first", req_ready, 4'b1000);
      tick();
      req_valid = '1;
      #1;
      chk("wrap_ptr0", req_ready, 4'b0001);
      req_valid = 4'b1010;
      #1;
      chk("wrap_second", req_ready, 4'b0010);
      tick();
      chk("wrap_third", req_ready, 4'b1000);
      tick();
      drain();

      // Reset while operations are in flight and buffered.
      rsp_ready = 1'b0;
      req_valid = '1;
      repeat (4) tick();
      #2;
      preset = 1'b1;
      #1;
      reset_check("mid");
      @(posedge clocked_on);
      #1;
      reset_check("mid_hold");
      preset = 1'b0;
      model_reset();
      #1;
      chk("mid_first_grant", req_ready, 4'b0001);
      repeat (7) tick();
      drain();

      // Zero-latency unit: result enters the FIFO at the edge after alu_fire.
      l0_req_a[2*W +: W]     = -64'sd3;
      l0_req_b[2*W +: W]     = 64'd4;
      l0_req_op[2*OPW +: OPW] = OP_MUL;
      l0_req_valid = 4'b0100;
      #1;
      chk("lat0_ready", l0_req_ready, 4'b0100);
      q0.push_back('{2'd2, 64'hFFFF_FFFF_FFFF_FFF4, 0});
      @(posedge clocked_on);
      #1;
      l0_req_valid = '0;
      chk("lat0_fire", l0_alu_fire, 1'b1);
      chk("lat0_a", l0_alu_a, 64'hFFFF_FFFF_FFFF_FFFD);
      chk("lat0_op", l0_alu_op, OP_MUL);
      chk("lat0_rsp_early", l0_rsp_valid, 1'b0);
      @(posedge clocked_on);
      #1;
      chk("lat0_rsp_valid", l0_rsp_valid, 1'b1);
      if (q0.size() > 0) begin
         e0 = q0.pop_front();
         chk("lat0_rsp_id", l0_rsp_id, e0.id);
         chk("lat0_rsp_z", l0_rsp_z, e0.z);
      end
      @(posedge clocked_on);
      #1;
      chk("lat0_rsp_gone", l0_rsp_valid, 1'b0);
      chk("lat0_busy", l0_busy, 1'b0);

      chk("final_busy", busy, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
